lcd_spi_arbiter: RTL and testbench

Sequencer and arbiter for the shared `spi_master` that drives the PCD8544 (84x48) LCD. After reset it runs the panel init sequence and a full-screen clear. It then grants the SPI link round-robin to two drawing requesters, such as the sprite drawer and the status-bar drawer. For each grant it frames the transfer as set-X command, set-Y command, then the requester's data bytes. It sits between the drawing blocks and `spi_master`, and owns the master's `data_in`, `start` and `command` inputs.

---
 rtl/lcd_spi_arbiter.sv | 136 +++++++++++++
 tb/tb_lcd_spi_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_arbiter.sv
// lcd_spi_arbiter: PCD8544 init/clear sequencer and round-robin SPI arbiter for two drawing requesters
module lcd_spi_arbiter #(
  parameter logic [7:0] VOP = 8'h90,
  parameter int CLEAR_BYTES = 504,
  parameter int LEN_W = 9
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic [1:0]         req,
  input  logic [13:0]        req_x,
  input  logic [5:0]         req_bank,
  input  logic [2*LEN_W-1:0] req_len,
  input  logic [15:0]        req_data,
  output logic [1:0]         grant,
  output logic [LEN_W-1:0]   byte_idx,
  output logic [1:0]         done,
  output logic               ready,
  output logic [7:0]         spi_data,
  output logic               spi_start,
  output logic               spi_cmd,
  input  logic               spi_avail
);
  typedef enum logic [2:0] {INIT, CLR_POS, CLEAR, IDLE, SET_X, SET_Y, DATA, DONE} state_t;
  localparam int CW = $clog2(CLEAR_BYTES + 1) < 2 ? 2 : $clog2(CLEAR_BYTES + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] data_r, init_next;
  logic [6:0] x_l;
  logic [2:0] bank_l;
  logic [LEN_W-1:0] len_l;
  logic win, win_l, last;
  assign win = &req ? ~last : req[1];
  assign init_next = cnt[1:0] == 2'd0 ? VOP : cnt[1:0] == 2'd1 ? 8'h20 : 8'h0C;
  // data bytes come straight from the granted requester so its ROM can follow byte_idx
  assign spi_data = state == DATA ? (win_l ? req_data[15:8] : req_data[7:0]) : data_r;
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state <= INIT;
      cnt <= '0;
      data_r <= 8'h00;
      spi_start <= 1'b0;
      spi_cmd <= 1'b0;
      grant <= 2'b00;
      done <= 2'b00;
      ready <= 1'b0;
      byte_idx <= '0;
      x_l <= '0;
      bank_l <= '0;
      len_l <= '0;
      win_l <= 1'b0;
      last <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          // first cycle out of reset only loads the first init byte
          if (!spi_start) begin
            spi_start <= 1'b1;
            data_r <= 8'h21;
          end else if (spi_avail) begin
            if (cnt == CW'(3)) begin
              state <= CLR_POS;
              cnt <= '0;
              data_r <= 8'h80;
            end else begin
              cnt <= cnt + 1'b1;
              data_r <= init_next;
            end
          end
        end
        CLR_POS: if (spi_avail) begin
          if (cnt == '0) begin
            cnt <= CW'(1);
            data_r <= 8'h40;
          end else begin
            state <= CLEAR;
            cnt <= '0;
            data_r <= 8'h00;
            spi_cmd <= 1'b1;
          end
        end
        CLEAR: if (spi_avail) begin
          if (cnt == CW'(CLEAR_BYTES - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
            spi_start <= 1'b0;
            spi_cmd <= 1'b0;
          end else
            cnt <= cnt + 1'b1;
        end
        IDLE: if (|req) begin
          state <= SET_X;
          grant <= win ? 2'b10 : 2'b01;
          win_l <= win;
          x_l <= win ? req_x[13:7] : req_x[6:0];
          bank_l <= win ? req_bank[5:3] : req_bank[2:0];
          len_l <= win ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
          data_r <= {1'b1, win ? req_x[13:7] : req_x[6:0]};
          spi_start <= 1'b1;
          spi_cmd <= 1'b0;
          byte_idx <= '0;
        end
        SET_X: if (spi_avail) begin
          state <= SET_Y;
          data_r <= {5'b01000, bank_l};
        end
        SET_Y: if (spi_avail) begin
          if (len_l != '0) begin
            state <= DATA;
            spi_cmd <= 1'b1;
          end else begin
            state <= DONE;
            spi_start <= 1'b0;
            done <= grant;
          end
        end
        DATA: if (spi_avail) begin
          if (byte_idx == len_l - LEN_W'(1)) begin
            state <= DONE;
            spi_start <= 1'b0;
            spi_cmd <= 1'b0;
            done <= grant;
          end else
            byte_idx <= byte_idx + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done <= 2'b00;
          grant <= 2'b00;
          last <= win_l;
          byte_idx <= '0;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// tb_lcd_spi_arbiter: directed checks of init/clear, single, contention, zero-length, streaming and reset-abort transfers
module tb_lcd_spi_arbiter;
  logic clock = 1'b0, Reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [13:0] req_x = '0;
  logic [5:0] req_bank = '0;
  logic [17:0] req_len = '0;
  logic [15:0] req_data;
  logic [1:0] grant, done;
  logic [8:0] byte_idx;
  logic ready, spi_start, spi_cmd, spi_avail = 1'b0;
  logic [7:0] spi_data;
  int n_tests = 0, n_fail = 0;

  lcd_spi_arbiter dut (
    .clock(clock), .Reset(Reset), .req(req), .req_x(req_x), .req_bank(req_bank),
    .req_len(req_len), .req_data(req_data), .grant(grant), .byte_idx(byte_idx),
    .done(done), .ready(ready), .spi_data(spi_data), .spi_start(spi_start),
    .spi_cmd(spi_cmd), .spi_avail(spi_avail)
  );

  always #5 clock = ~clock;
  assign req_data = {8'hB0 + byte_idx[7:0], 8'hA0 + byte_idx[7:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic take(input logic [7:0] d, input logic c, input int gap, input string tag);
    repeat (gap) @(negedge clock);
    chk({tag, "_start"}, spi_start, 1);
    chk({tag, "_data"}, spi_data, d);
    chk({tag, "_cmd"}, spi_cmd, c);
    spi_avail = 1'b1;
    @(negedge clock);
    spi_avail = 1'b0;
  endtask

  task automatic set_req(input int n, input logic [6:0] x, input logic [2:0] b, input logic [8:0] l);
    if (n == 0) begin
      req_x[6:0] = x; req_bank[2:0] = b; req_len[8:0] = l;
    end else begin
      req_x[13:7] = x; req_bank[5:3] = b; req_len[17:9] = l;
    end
  endtask

  logic [7:0] init_seq [6] = '{8'h21, 8'h90, 8'h20, 8'h0C, 8'h80, 8'h40};
  logic [7:0] exp_x [4] = '{8'h82, 8'h81, 8'h82, 8'h81};
  logic [7:0] exp_y [4] = '{8'h41, 8'h40, 8'h41, 8'h40};
  logic [7:0] exp_d [4] = '{8'hB0, 8'hA0, 8'hB0, 8'hA0};
  logic [1:0] exp_g [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [7:0] stream [6] = '{8'h83, 8'h44, 8'hB0, 8'hB1, 8'hB2, 8'hB3};

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_start", spi_start, 0);
    chk("rst_cmd", spi_cmd, 0);
    chk("rst_data", spi_data, 8'h00);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 0);
    chk("rst_idx", byte_idx, 0);
    // request held during init must not be granted early
    set_req(0, 7'd10, 3'd2, 9'd3);
    req = 2'b01;
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      take(init_seq[i], 1'b0, i == 0 ? 1 : 3, "init");
      chk("init_grant", grant, 0);
    end
    for (int i = 0; i < 504; i++) begin
      if (i == 503) chk("ready_early", ready, 0);
      take(8'h00, 1'b1, 3, "clear");
    end
    chk("ready_up", ready, 1);
    chk("idle_grant", grant, 0);
    chk("idle_start", spi_start, 0);
    take(8'h8A, 1'b0, 1, "s_x");
    chk("s_grant", grant, 2'b01);
    take(8'h42, 1'b0, 0, "s_y");
    for (int i = 0; i < 3; i++) begin
      chk("s_idx", byte_idx, i);
      take(8'hA0 + 8'(i), 1'b1, 0, "s_dat");
    end
    chk("s_done", done, 2'b01);
    req = 2'b00;
    @(negedge clock);
    chk("s_done_clr", done, 0);
    chk("s_grant_clr", grant, 0);
    set_req(0, 7'd2, 3'd1, 9'd1);
    set_req(1, 7'd1, 3'd0, 9'd1);
    set_req(0, 7'd1, 3'd0, 9'd1);
    set_req(1, 7'd2, 3'd1, 9'd1);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      take(exp_x[k], 1'b0, 1, "c_x");
      chk("c_grant", grant, exp_g[k]);
      take(exp_y[k], 1'b0, 0, "c_y");
      take(exp_d[k], 1'b1, 0, "c_dat");
      chk("c_done", done, exp_g[k]);
      @(negedge clock);
      chk("c_idle_grant", grant, 0);
    end
    req = 2'b00;
    set_req(0, 7'd0, 3'd5, 9'd0);
    req = 2'b01;
    take(8'h80, 1'b0, 1, "z_x");
    take(8'h45, 1'b0, 0, "z_y");
    chk("z_idx", byte_idx, 0);
    chk("z_done", done, 2'b01);
    req = 2'b00;
    @(negedge clock);
    chk("z_done_clr", done, 0);
    set_req(1, 7'd3, 3'd4, 9'd4);
    req = 2'b10;
    spi_avail = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("b_start", spi_start, 1);
      chk("b_data", spi_data, stream[i]);
      chk("b_cmd", spi_cmd, i >= 2);
    end
    @(negedge clock);
    chk("b_done", done, 2'b10);
    req = 2'b00;
    spi_avail = 1'b0;
    @(negedge clock);
    set_req(0, 7'd7, 3'd1, 9'd5);
    req = 2'b01;
    take(8'h87, 1'b0, 1, "r_x");
    take(8'h41, 1'b0, 0, "r_y");
    take(8'hA0, 1'b1, 0, "r_d0");
    take(8'hA1, 1'b1, 0, "r_d1");
    chk("r_idx", byte_idx, 2);
    Reset = 1'b1;
    #1;
    chk("r_start", spi_start, 0);
    chk("r_cmd", spi_cmd, 0);
    chk("r_data", spi_data, 8'h00);
    chk("r_grant", grant, 0);
    chk("r_done", done, 0);
    chk("r_ready", ready, 0);
    chk("r_idx0", byte_idx, 0);
    req = 2'b00;
    @(negedge clock);
    Reset = 1'b0;
    @(negedge clock);
    chk("r_restart_start", spi_start, 1);
    chk("r_restart_data", spi_data, 8'h21);
    chk("r_restart_cmd", spi_cmd, 0);
    repeat (4) begin
      @(negedge clock);
      chk("r_no_done", done, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
